// File: rtl/qspi_rx_ctrl.sv
// QSPI receive-side sequencer: runs dummy cycles, counts nibbles per word and
// words per transfer, and stalls SCLK while the consumer has not taken a word.
module qspi_rx_ctrl (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [4:0] dummy_i,
  input  logic [3:0] nibbles_i,
  input  logic [7:0] words_i,
  input  logic       msb_first_i,
  input  logic       sample_i,
  input  logic       ready_i,
  input  logic       abort_i,
  output logic       sclk_en_o,
  output logic       shift_valid_o,
  output logic       shift_lsb_o,
  output logic       shift_msb_o,
  output logic       data_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DUMMY = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0] r_state,     w_state_nxt;
  logic [4:0] r_dummy_cnt, w_dummy_cnt_nxt;
  logic [3:0] r_nib_cnt,   w_nib_cnt_nxt;
  logic [3:0] r_nib_cfg,   w_nib_cfg_nxt;
  logic [7:0] r_word_cnt,  w_word_cnt_nxt;
  logic       r_msb,       w_msb_nxt;
  logic       r_done,      w_done_nxt;
  logic       r_data_valid;

  logic [3:0] w_nib_eff;
  logic [7:0] w_words_eff;

  // Out-of-range nibble counts saturate to a full 32-bit word.
  assign w_nib_eff   = ((nibbles_i == 4'd0) || (nibbles_i > 4'd8)) ? 4'd8 : nibbles_i;
  assign w_words_eff = (words_i == 8'd0) ? 8'd1 : words_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_dummy_cnt_nxt = r_dummy_cnt;
    w_nib_cnt_nxt   = r_nib_cnt;
    w_nib_cfg_nxt   = r_nib_cfg;
    w_word_cnt_nxt  = r_word_cnt;
    w_msb_nxt       = r_msb;
    w_done_nxt      = 1'b0;

    if (r_state == S_IDLE) begin
      if (start_i && !abort_i) begin
        w_dummy_cnt_nxt = dummy_i;
        w_nib_cnt_nxt   = w_nib_eff;
        w_nib_cfg_nxt   = w_nib_eff;
        w_word_cnt_nxt  = w_words_eff;
        w_msb_nxt       = msb_first_i;
        w_state_nxt     = (dummy_i != 5'd0) ? S_DUMMY : S_SHIFT;
      end
    end else if (abort_i) begin
      w_state_nxt     = S_IDLE;
      w_dummy_cnt_nxt = 5'd0;
      w_nib_cnt_nxt   = 4'd0;
      w_nib_cfg_nxt   = 4'd0;
      w_word_cnt_nxt  = 8'd0;
      w_msb_nxt       = 1'b0;
    end else begin
      case (r_state)
        S_DUMMY: begin
          if (sample_i) begin
            w_dummy_cnt_nxt = r_dummy_cnt - 5'd1;
            if (r_dummy_cnt == 5'd1) w_state_nxt = S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (sample_i) begin
            w_nib_cnt_nxt = r_nib_cnt - 4'd1;
            if (r_nib_cnt == 4'd1) w_state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (ready_i) begin
            w_word_cnt_nxt = r_word_cnt - 8'd1;
            if (r_word_cnt == 8'd1) begin
              w_state_nxt   = S_IDLE;
              w_nib_cfg_nxt = 4'd0;
              w_msb_nxt     = 1'b0;
              w_done_nxt    = 1'b1;
            end else begin
              // Following words go straight back to shifting, no dummy phase.
              w_nib_cnt_nxt = r_nib_cfg;
              w_state_nxt   = S_SHIFT;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_dummy_cnt  <= 5'd0;
      r_nib_cnt    <= 4'd0;
      r_nib_cfg    <= 4'd0;
      r_word_cnt   <= 8'd0;
      r_msb        <= 1'b0;
      r_done       <= 1'b0;
      r_data_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dummy_cnt  <= w_dummy_cnt_nxt;
      r_nib_cnt    <= w_nib_cnt_nxt;
      r_nib_cfg    <= w_nib_cfg_nxt;
      r_word_cnt   <= w_word_cnt_nxt;
      r_msb        <= w_msb_nxt;
      r_done       <= w_done_nxt;
      r_data_valid <= (w_state_nxt == S_HOLD);
    end
  end

  assign busy_o        = (r_state != S_IDLE);
  assign sclk_en_o     = (r_state == S_DUMMY) || (r_state == S_SHIFT);
  // An abort in the same cycle suppresses the shift strobe.
  assign shift_valid_o = (r_state == S_SHIFT) && sample_i && !abort_i;
  assign shift_msb_o   = busy_o && r_msb;
  assign shift_lsb_o   = busy_o && !r_msb;
  assign data_valid_o  = r_data_valid;
  assign done_o        = r_done;

endmodule

// File: doc/qspi_rx_ctrl.md
QSPI_RX_CTRL -- requirements
Module: qspi_rx_ctrl

Interface
REQ-001 SHALL have no parameters; all counter widths are fixed by the port list.
REQ-002 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 start_i  input  1  one-cycle request to begin a receive transfer; honoured only in IDLE.
REQ-005 dummy_i  input  5  dummy SCLK sample count before data, 0..31; latched on accepted start.
REQ-006 nibbles_i  input  4  nibbles per word; 0 or >8 treated as 8; latched on accepted start.
REQ-007 words_i  input  8  words per transfer; 0 treated as 1; latched on accepted start.
REQ-008 msb_first_i  input  1  shift order, 1=msb mode, 0=lsb mode; latched on accepted start.
REQ-009 sample_i  input  1  one-cycle strobe from the SCLK generator marking the input sampling edge.
REQ-010 ready_i  input  1  consumer accepts the current word.
REQ-011 abort_i  input  1  synchronous transfer abort.
REQ-012 sclk_en_o  output  1  permits the SCLK generator to toggle.
REQ-013 shift_valid_o  output  1  enable to the RX shift register.
REQ-014 shift_lsb_o  output  1  lsb-mode select to the RX shift register.
REQ-015 shift_msb_o  output  1  msb-mode select to the RX shift register.
REQ-016 data_valid_o  output  1  shift register holds a complete word.
REQ-017 busy_o  output  1  transfer in progress.
REQ-018 done_o  output  1  one-cycle pulse on normal transfer completion.

Function
REQ-019 SHALL implement states IDLE, DUMMY, SHIFT, HOLD.
REQ-020 IDLE: on start_i, latch config and go to DUMMY if dummy_i!=0, else SHIFT; busy_o=0 only in IDLE.
REQ-021 DUMMY: decrement dummy counter on each sample_i; the sample_i that consumes the last count moves to SHIFT; no shift_valid_o.
REQ-022 SHIFT: shift_valid_o = sample_i (combinational, same cycle); decrement nibble counter per sample_i; the last-nibble sample moves to HOLD.
REQ-023 shift_msb_o = latched msb_first; shift_lsb_o = its inverse; both held constant from start acceptance until return to IDLE; both 0 in IDLE.
REQ-024 sclk_en_o=1 in DUMMY and SHIFT only; 0 in IDLE and HOLD (SCLK stalls under back-pressure).
REQ-025 HOLD: data_valid_o=1 (registered, first asserted the cycle after the last sample); sample_i ignored.
REQ-026 HOLD with ready_i: decrement word counter; if it was the last word, go to IDLE and pulse done_o the same cycle the IDLE state is entered; else reload nibble counter and go to SHIFT (no dummy phase between words).
REQ-027 data_valid_o SHALL drop the cycle after the accepting ready_i.
REQ-028 abort_i in any non-IDLE state: next state IDLE, all outputs return to reset values, no done_o; abort_i beats ready_i and sample_i in the same cycle.
REQ-029 start_i while busy_o=1 SHALL be ignored; start_i with abort_i in IDLE SHALL be ignored.
REQ-030 ready_i outside HOLD SHALL have no effect.

Reset
REQ-031 While rst_ni=0: state IDLE, all counters 0, every output 0.
REQ-032 Reset mid-transfer SHALL discard latched config; first activity after release requires a new start_i.

Verification
REQ-033 start, dummy=0, nibbles=8, words=1, msb_first=0, 8 sample_i pulses, ready_i held 1 -> 8 shift_valid_o pulses with shift_lsb_o=1, data_valid_o 1 cycle, done_o pulse, busy_o 0 after.
REQ-034 dummy=4, nibbles=2 -> first 4 sample_i give no shift_valid_o, next 2 do; sclk_en_o 1 throughout both phases.
REQ-035 words=3, ready_i low 5 cycles on word 2 -> sclk_en_o 0 and sample_i ignored during stall, data_valid_o held, exactly 3 words delivered, one done_o.
REQ-036 abort_i asserted during SHIFT after 3 of 8 nibbles -> IDLE next cycle, no done_o, no data_valid_o; new start accepted afterwards.
REQ-037 nibbles_i=0 and nibbles_i=12 -> 8 shift_valid_o pulses each; words_i=0 -> one word.
REQ-038 rst_ni low in HOLD, then start_i during SHIFT of the next transfer -> outputs 0 on reset; second start_i ignored.
